pool_window_gen: RTL and testbench

POOL_WINDOW_GEN -- requirements
Module: pool_window_gen

---
 rtl/cnn_pkg.sv | 22 ++
 rtl/pool_line_buffer.sv | 30 +++
 rtl/pool_window_gen.sv | 130 +++++++++++++
 tb/tb_pool_window_gen.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants: sample width, packed 2x2 window layout and
// field helpers used by the pooling window generator and the maxpool stage.
package cnn_pkg;

    localparam int CNN_DATA_W   = 24;
    localparam int CNN_WIN_TAPS = 4;
    localparam int CNN_WIN_W    = CNN_WIN_TAPS * CNN_DATA_W;

    // Field order inside a packed window, lowest slice first.
    localparam int WIN_TL = 0;
    localparam int WIN_TR = 1;
    localparam int WIN_BL = 2;
    localparam int WIN_BR = 3;

    typedef logic [CNN_DATA_W-1:0] cnn_sample_t;
    typedef logic [CNN_WIN_W-1:0]  cnn_window_t;

    function automatic int win_lsb(input int field, input int data_w);
        return field * data_w;
    endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// One-row line buffer for 2x2 pooling: single synchronous write port and two
// combinational read ports, small enough to map onto distributed RAM.
module pool_line_buffer #(
    parameter int DEPTH  = 222,
    parameter int DATA_W = 24,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [AW-1:0]     i_rd_addr_a,
    output logic [DATA_W-1:0] o_rd_data_a,
    input  logic [AW-1:0]     i_rd_addr_b,
    output logic [DATA_W-1:0] o_rd_data_b
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Storage write; contents deliberately unreset since each even row refills them.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem_q[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data_a = mem_q[i_rd_addr_a];
    assign o_rd_data_b = mem_q[i_rd_addr_b];

endmodule

// File: rtl/pool_window_gen.sv
// Builds non-overlapping stride-2 2x2 windows from a raster conv-output stream
// and presents each one for a single cycle, one clock after its last sample.
module pool_window_gen
    import cnn_pkg::*;
#(
    parameter int IMG_WIDTH  = 222,
    parameter int IMG_HEIGHT = 222,
    parameter int DATA_W     = CNN_DATA_W
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [DATA_W-1:0]   i_pixel_data,
    input  logic                i_pixel_data_valid,
    output logic [4*DATA_W-1:0] o_convolved_data,
    output logic                o_convolved_data_valid,
    output logic                o_frame_done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic [DATA_W-1:0]     hold_q, hold_d;
    logic [4*DATA_W-1:0]   win_q, win_d;
    logic                  vld_q, vld_d;
    logic                  done_q, done_d;

    logic                  col_last_s;
    logic                  row_last_s;
    logic                  wr_en_s;
    logic                  capture_s;
    logic                  emit_s;
    logic [CW-1:0]         rd_addr_left_s;
    logic [DATA_W-1:0]     rd_left_s;
    logic [DATA_W-1:0]     rd_right_s;

    // Emission only happens on odd columns, so clearing bit 0 addresses the left neighbour.
    assign rd_addr_left_s = col_q & ~COL_ONE;

    pool_line_buffer #(
        .DEPTH  (IMG_WIDTH),
        .DATA_W (DATA_W),
        .AW     (CW)
    ) u_line_buf (
        .i_clk       (i_clk),
        .i_wr_en     (wr_en_s),
        .i_wr_addr   (col_q),
        .i_wr_data   (i_pixel_data),
        .i_rd_addr_a (rd_addr_left_s),
        .o_rd_data_a (rd_left_s),
        .i_rd_addr_b (col_q),
        .o_rd_data_b (rd_right_s)
    );

    // Position decode and raster counters, advanced only by accepted samples.
    always_comb begin
        col_last_s = (col_q == COL_LAST);
        row_last_s = (row_q == ROW_LAST);
        wr_en_s    = i_pixel_data_valid & ~row_q[0];
        capture_s  = i_pixel_data_valid &  row_q[0] & ~col_q[0];
        emit_s     = i_pixel_data_valid &  row_q[0] &  col_q[0];
        col_d      = col_q;
        row_d      = row_q;
        if (i_pixel_data_valid) begin
            if (col_last_s) begin
                col_d = {CW{1'b0}};
                if (row_last_s) begin
                    row_d = {RW{1'b0}};
                end else begin
                    row_d = row_q + ROW_ONE;
                end
            end else begin
                col_d = col_q + COL_ONE;
            end
        end else begin
            col_d = col_q;
            row_d = row_q;
        end
    end

    // Hold register and window assembly; the window holds its value between strobes.
    always_comb begin
        hold_d = hold_q;
        win_d  = win_q;
        vld_d  = emit_s;
        done_d = emit_s & row_last_s & col_last_s;
        if (capture_s) begin
            hold_d = i_pixel_data;
        end else begin
            hold_d = hold_q;
        end
        if (emit_s) begin
            win_d[win_lsb(WIN_TL, DATA_W) +: DATA_W] = rd_left_s;
            win_d[win_lsb(WIN_TR, DATA_W) +: DATA_W] = rd_right_s;
            win_d[win_lsb(WIN_BL, DATA_W) +: DATA_W] = hold_q;
            win_d[win_lsb(WIN_BR, DATA_W) +: DATA_W] = i_pixel_data;
        end else begin
            win_d = win_q;
        end
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col_q  <= {CW{1'b0}};
            row_q  <= {RW{1'b0}};
            hold_q <= {DATA_W{1'b0}};
            win_q  <= {(4*DATA_W){1'b0}};
            vld_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            hold_q <= hold_d;
            win_q  <= win_d;
            vld_q  <= vld_d;
            done_q <= done_d;
        end
    end

    assign o_convolved_data       = win_q;
    assign o_convolved_data_valid = vld_q;
    assign o_frame_done           = done_q;

endmodule

// File: tb/tb_pool_window_gen.sv
// Self-checking bench: a 4x4 instance for directed/table/corner cases and a
// default-size instance checked against a frame-array reference model.
module tb_pool_window_gen;

    localparam int DW = 24;
    localparam int AW_IMG = 4;
    localparam int BW = 222;
    localparam int BH = 222;

    localparam logic [95:0] W1 = {24'd6,  24'd5,  24'd2,  24'd1};
    localparam logic [95:0] W2 = {24'd8,  24'd7,  24'd4,  24'd3};
    localparam logic [95:0] W3 = {24'd14, 24'd13, 24'd10, 24'd9};
    localparam logic [95:0] W4 = {24'd16, 24'd15, 24'd12, 24'd11};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [DW-1:0]   a_pix, b_pix;
    logic            a_vld, b_vld;
    logic [4*DW-1:0] a_win, b_win;
    logic            a_wv, b_wv, a_done, b_done;

    pool_window_gen #(.IMG_WIDTH(AW_IMG), .IMG_HEIGHT(AW_IMG), .DATA_W(DW)) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_pixel_data(a_pix), .i_pixel_data_valid(a_vld),
        .o_convolved_data(a_win), .o_convolved_data_valid(a_wv), .o_frame_done(a_done));

    pool_window_gen u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_pixel_data(b_pix), .i_pixel_data_valid(b_vld),
        .o_convolved_data(b_win), .o_convolved_data_valid(b_wv), .o_frame_done(b_done));

    typedef struct {
        logic [23:0] pix;
        logic        exp_v;
        logic        exp_d;
        logic [95:0] exp_w;
    } vec_t;

    vec_t        tbl [16];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [95:0] a_exp_win;
    logic [95:0] a_got_q [$];
    int          a_done_cnt;
    logic [23:0] fr1 [16];
    logic [23:0] fr101 [16];
    logic [23:0] frs [16];
    logic [23:0] b_frame [BW*BH];

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_idle();
        a_vld = 1'b0;
        tick();
        chk("a_gap_valid", 96'(a_wv), 96'd0);
        chk("a_gap_hold", a_win, a_exp_win);
    endtask

    // Sends one 4x4 frame; expectations come from row/col arithmetic on the frame array.
    task automatic a_frame(input logic [23:0] px [16], input bit gaps);
        int g;
        for (int k = 0; k < 16; k++) begin
            g = gaps ? int'($urandom_range(0, 3)) : 0;
            for (int i = 0; i < g; i++) a_idle();
            a_pix = px[k];
            a_vld = 1'b1;
            tick();
            a_vld = 1'b0;
            if (((k / 4) % 2 == 1) && ((k % 4) % 2 == 1)) begin
                a_exp_win = {px[k], px[k-1], px[k-4], px[k-5]};
                chk("a_win_valid", 96'(a_wv), 96'd1);
                chk("a_win_data", a_win, a_exp_win);
                chk("a_frame_done", 96'(a_done), (k == 15) ? 96'd1 : 96'd0);
                a_got_q.push_back(a_win);
                if (a_done) a_done_cnt++;
            end else begin
                chk("a_no_valid", 96'(a_wv), 96'd0);
                chk("a_no_done", 96'(a_done), 96'd0);
                chk("a_hold_data", a_win, a_exp_win);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_wins;
        int b_dones;
        logic [95:0] bexp;
        a_vld = 1'b0; b_vld = 1'b0; a_pix = '0; b_pix = '0;
        a_exp_win = 96'd0; a_done_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            fr1[k]   = 24'(k + 1);
            fr101[k] = 24'(k + 101);
            frs[k]   = 24'($urandom);
            tbl[k].pix   = 24'(k + 1);
            tbl[k].exp_v = (k == 5 || k == 7 || k == 13 || k == 15);
            tbl[k].exp_d = (k == 15);
            tbl[k].exp_w = (k < 5) ? 96'd0 : (k < 7) ? W1 : (k < 13) ? W2 : (k < 15) ? W3 : W4;
        end
        frs[0] = 24'hFFFFFB;
        frs[1] = 24'hFFFFFF;
        frs[4] = 24'h800000;
        frs[5] = 24'h7FFFFF;

        // Reset state.
        rst_n = 1'b0;
        #2;
        chk("rst_valid", 96'(a_wv), 96'd0);
        chk("rst_done", 96'(a_done), 96'd0);
        chk("rst_data", a_win, 96'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Basic 4x4 stream, continuous valid, from the table.
        for (int k = 0; k < 16; k++) begin
            a_pix = tbl[k].pix;
            a_vld = 1'b1;
            tick();
            a_vld = 1'b0;
            chk("tbl_valid", 96'(a_wv), 96'(tbl[k].exp_v));
            chk("tbl_done", 96'(a_done), 96'(tbl[k].exp_d));
            chk("tbl_data", a_win, tbl[k].exp_w);
        end
        a_exp_win = W4;
        a_idle();

        // Same stream with random valid gaps.
        a_got_q.delete();
        a_frame(fr1, 1'b1);
        chk("gap_count", 96'(a_got_q.size()), 96'd4);
        if (a_got_q.size() == 4) begin
            chk("gap_w1", a_got_q[0], W1);
            chk("gap_w4", a_got_q[3], W4);
        end

        // Signed extremes pass bit-exact.
        a_got_q.delete();
        a_frame(frs, 1'b0);
        if (a_got_q.size() > 0) chk("signed_win", a_got_q[0], 96'h7FFFFF_800000_FFFFFF_FFFFFB);
        else chk("signed_count", 96'(a_got_q.size()), 96'd4);

        // Two frames back to back with no idle cycle.
        a_got_q.delete();
        a_done_cnt = 0;
        a_frame(fr1, 1'b0);
        a_frame(fr101, 1'b0);
        chk("b2b_count", 96'(a_got_q.size()), 96'd8);
        chk("b2b_dones", 96'(a_done_cnt), 96'd2);
        if (a_got_q.size() > 4) chk("b2b_f2_first", a_got_q[4], {24'd106, 24'd105, 24'd102, 24'd101});

        // Reset after sample 7 of a frame, then a clean frame.
        for (int k = 0; k < 7; k++) begin
            a_pix = fr1[k];
            a_vld = 1'b1;
            tick();
        end
        a_vld = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 96'(a_wv), 96'd0);
        chk("mid_rst_data", a_win, 96'd0);
        tick();
        chk("mid_rst_hold_valid", 96'(a_wv), 96'd0);
        rst_n = 1'b1;
        a_exp_win = 96'd0;
        a_got_q.delete();
        a_done_cnt = 0;
        a_frame(fr1, 1'b0);
        chk("rst_count", 96'(a_got_q.size()), 96'd4);
        chk("rst_dones", 96'(a_done_cnt), 96'd1);
        if (a_got_q.size() == 4) begin
            chk("rst_w1", a_got_q[0], W1);
            chk("rst_w2", a_got_q[1], W2);
            chk("rst_w3", a_got_q[2], W3);
            chk("rst_w4", a_got_q[3], W4);
        end

        // Default-size frame with random data and sparse gaps.
        b_wins = 0;
        b_dones = 0;
        for (int k = 0; k < BW * BH; k++) begin
            if ($urandom_range(0, 15) == 0) begin
                b_vld = 1'b0;
                tick();
                chk("b_gap_valid", 96'(b_wv), 96'd0);
            end
            b_frame[k] = 24'($urandom);
            b_pix = b_frame[k];
            b_vld = 1'b1;
            tick();
            b_vld = 1'b0;
            if (((k / BW) % 2 == 1) && ((k % BW) % 2 == 1)) begin
                bexp = {b_frame[k], b_frame[k-1], b_frame[k-BW], b_frame[k-BW-1]};
                chk("b_win_valid", 96'(b_wv), 96'd1);
                chk("b_win_data", b_win, bexp);
                chk("b_frame_done", 96'(b_done), (k == BW * BH - 1) ? 96'd1 : 96'd0);
            end else begin
                chk("b_no_valid", 96'(b_wv), 96'd0);
            end
            if (b_wv) b_wins++;
            if (b_done) b_dones++;
        end
        chk("b_win_count", 96'(b_wins), 96'(111 * 111));
        chk("b_done_count", 96'(b_dones), 96'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
